simon_button_encoder: RTL

//  Player-input front end for the Simon game core. Takes four raw, asynchronous, bouncing

---
 rtl/simon_pkg.sv | 28 ++
 rtl/simon_debounce.sv | 52 +++++
 rtl/simon_button_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon player-input front end.
package simon_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned BTN_W   = 2;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PULSE,
    HOLD
  } btn_state_t;

  // Index of the single set bit; callers only use it on a one-hot vector.
  function automatic logic [BTN_W-1:0] onehot4_to_idx(input logic [NUM_BTN-1:0] oneHot);
    logic [BTN_W-1:0] idx;
    idx = '0;
    unique case (oneHot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// Two-flop synchronizer plus whole-vector debounce for the four Simon buttons.
// A new vector is accepted once DEBOUNCE_TICKS consecutive synced samples agree.
module simon_debounce
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] raw,
  output logic [NUM_BTN-1:0] stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] cand;
  logic [CNT_W-1:0]   cnt;

  // Bring the asynchronous buttons into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Track a candidate vector and how long it has been steady; publish it once settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cnt == CNT_MAX) begin
        stable <= cand;
      end
    end
  end

endmodule

// File: rtl/simon_button_encoder.sv
// Player-input front end for the Simon core: debounced buttons, one strobe per press,
// multi-button and out-of-turn presses rejected.
// Optional stuck-button detector enabled by defining SIMON_BTN_STUCK_DETECT_EN.
module simon_button_encoder
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned STUCK_TICKS    = 600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [BTN_W-1:0]   player_num,
  output logic               player_pressed,
  output logic [NUM_BTN-1:0] btn_held,
  output logic               stuck
);

  // btn_held is cleared by reset, so a button held through reset would look like a fresh
  // press once it has been debounced. WAIT_REL therefore demands enough consecutive
  // released cycles to cover the synchronizer and debounce pipeline before arming.
  localparam int unsigned REL_WAIT = DEBOUNCE_TICKS + 3;
  localparam int unsigned REL_W    = $clog2(REL_WAIT + 1);
  localparam logic [REL_W-1:0] REL_MAX = REL_W'(REL_WAIT);

  btn_state_t         state;
  btn_state_t         stateNext;
  logic [REL_W-1:0]   relCnt;
  logic [REL_W-1:0]   relCntNext;
  logic               numLoad;

  simon_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_raw),
    .stable(btn_held)
  );

  // State, release-wait counter and the latched button index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_REL;
      relCnt     <= '0;
      player_num <= '0;
    end else begin
      state  <= stateNext;
      relCnt <= relCntNext;
      if (numLoad) begin
        player_num <= onehot4_to_idx(btn_held);
      end
    end
  end

  // Press acceptance: one strobe per full release/press, single button, player's turn only.
  always_comb begin
    stateNext  = state;
    relCntNext = relCnt;
    numLoad    = 1'b0;
    unique case (state)
      WAIT_REL: begin
        if (btn_held != '0) begin
          relCntNext = '0;
        end else if (relCnt == REL_MAX) begin
          stateNext = IDLE;
        end else begin
          relCntNext = relCnt + REL_W'(1);
        end
      end
      IDLE: begin
        if (btn_held != '0) begin
          if ($onehot(btn_held) && enable) begin
            stateNext = PULSE;
            numLoad   = 1'b1;
          end else begin
            stateNext = HOLD;
          end
        end
      end
      PULSE: stateNext = HOLD;
      HOLD: begin
        if (btn_held == '0) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = WAIT_REL;
    endcase
  end

  assign player_pressed = (state == PULSE);

`ifdef SIMON_BTN_STUCK_DETECT_EN
  localparam int unsigned STUCK_W = $clog2(64'(STUCK_TICKS) + 64'd1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_TICKS);

  logic [STUCK_W-1:0] stuckCnt;

  // Count cycles spent in HOLD, saturating; any other state restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuckCnt <= '0;
    end else if (state != HOLD) begin
      stuckCnt <= '0;
    end else if (stuckCnt != STUCK_MAX) begin
      stuckCnt <= stuckCnt + STUCK_W'(1);
    end
  end

  assign stuck = (state == HOLD) && (stuckCnt == STUCK_MAX);
`else
  assign stuck = 1'b0;
`endif

endmodule
